// File: rtl/dff_sr_checker.sv
// dff_sr_checker: LFSR-driven stimulus and golden-model checker for a
// synchronous set/reset D flip-flop. Drives d/Set/Reset into the DUT, tracks
// the expected q in parallel, and counts cycles where q/n_q disagree.
module dff_sr_checker #(
    parameter int unsigned N_VECTORS = 64,
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    parameter int unsigned ERR_W     = 8
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             start,
    output logic             dut_d,
    output logic             dut_Set,
    output logic             dut_Reset,
    input  logic             dut_q,
    input  logic             dut_n_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       first_err_idx
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(N_VECTORS - 1);

    state_t             state;
    logic [7:0]         lfsr;
    logic [7:0]         lfsr_next;
    logic [7:0]         idx;
    logic               exp_q;
    logic               chk_v;
    logic [7:0]         chk_idx;
    logic               mismatch;
    logic [ERR_W-1:0]   err_next;

    // Fibonacci LFSR step, taps x^8+x^6+x^5+x^4+1.
    always_comb begin
        lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Compare DUT against the golden value and form the saturating count.
    always_comb begin
        mismatch = chk_v && ((dut_q != exp_q) || (dut_n_q != ~exp_q));
        err_next = err_count;
        if (mismatch && (err_count != '1)) begin
            err_next = err_count + ERR_W'(1);
        end
    end

    // Golden flip-flop plus the one-cycle check-valid/index pipeline.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            exp_q   <= 1'b0;
            chk_v   <= 1'b0;
            chk_idx <= '0;
        end else begin
            if (dut_Reset) begin
                exp_q <= 1'b0;
            end else if (dut_Set) begin
                exp_q <= 1'b1;
            end else begin
                exp_q <= dut_d;
            end
            chk_v   <= (state == RUN);
            chk_idx <= idx;
        end
    end

    // Run-control FSM with registered stimulus and result outputs.
    // Result tracking is written first so a start in IDLE/DONE overrides it.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            lfsr          <= LFSR_SEED;
            idx           <= '0;
            dut_d         <= 1'b0;
            dut_Set       <= 1'b0;
            dut_Reset     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= 8'hFF;
        end else begin
            err_count <= err_next;
            if (mismatch && (err_count == '0)) begin
                first_err_idx <= chk_idx;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        lfsr          <= LFSR_SEED;
                        idx           <= '0;
                        err_count     <= '0;
                        first_err_idx <= 8'hFF;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        dut_d         <= 1'b0;
                        dut_Set       <= 1'b0;
                        dut_Reset     <= 1'b1;
                    end
                end
                RUN: begin
                    lfsr <= lfsr_next;
                    idx  <= idx + 8'd1;
                    if (idx == LAST_IDX) begin
                        state     <= DRAIN;
                        dut_d     <= 1'b0;
                        dut_Set   <= 1'b0;
                        dut_Reset <= 1'b0;
                    end else begin
                        dut_d     <= lfsr_next[0];
                        dut_Set   <= lfsr_next[3] & lfsr_next[5];
                        dut_Reset <= lfsr_next[2] & lfsr_next[6] & lfsr_next[7];
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_next == '0);
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_sr_checker.sv
// Testbench for dff_sr_checker: behavioural flip-flops with selectable faults
// stand in for the DUT; expectations come from a vector table built from the
// LFSR sequence and the flip-flop rules.
module tb_dff_sr_checker;

    localparam int N = 64;
    localparam logic [7:0] SEED = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       start2;
    int         mode;

    logic       dut_d, dut_Set, dut_Reset, dut_q, dut_n_q;
    logic       busy, done, pass;
    logic [7:0] err_count, first_err_idx;

    logic       d2, s2, r2, q2, nq2;
    logic       busy2, done2, pass2;
    logic [1:0] err2;
    logic [7:0] fidx2;

    logic       ff_q  = 1'b0;
    logic       ff2_q = 1'b0;

    int checks = 0;
    int errors = 0;

    // model tables
    logic vd [N];
    logic vs [N];
    logic vr [N];
    logic ve [N];

    // observations from the last main run
    logic od [N];
    logic os [N];
    logic obs_r [N];
    int   nbusy;
    logic drain_nonzero;

    dff_sr_checker u_dut (
        .clk           (clk),
        .Reset_n       (rst_n),
        .start         (start),
        .dut_d         (dut_d),
        .dut_Set       (dut_Set),
        .dut_Reset     (dut_Reset),
        .dut_q         (dut_q),
        .dut_n_q       (dut_n_q),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    dff_sr_checker #(.ERR_W(2)) u_dut_w2 (
        .clk           (clk),
        .Reset_n       (rst_n),
        .start         (start2),
        .dut_d         (d2),
        .dut_Set       (s2),
        .dut_Reset     (r2),
        .dut_q         (q2),
        .dut_n_q       (nq2),
        .busy          (busy2),
        .done          (done2),
        .pass          (pass2),
        .err_count     (err2),
        .first_err_idx (fidx2)
    );

    // flip-flop under test; mode 2 lets Set win over Reset
    always @(posedge clk) begin
        if (mode == 2)
            ff_q <= dut_Set ? 1'b1 : (dut_Reset ? 1'b0 : dut_d);
        else
            ff_q <= dut_Reset ? 1'b0 : (dut_Set ? 1'b1 : dut_d);
    end
    assign dut_q   = (mode == 1) ? 1'b0 : ff_q;
    assign dut_n_q = (mode == 3) ? ff_q : ~ff_q;

    // second flip-flop, output q stuck at 0
    always @(posedge clk) begin
        ff2_q <= r2 ? 1'b0 : (s2 ? 1'b1 : d2);
    end
    assign q2  = 1'b0;
    assign nq2 = ~ff2_q;

    function automatic logic [7:0] step(input logic [7:0] x);
        return {x[6:0], ^(x & 8'hB8)};
    endfunction

    task automatic build_model();
        logic [7:0] x;
        x = SEED;
        for (int i = 0; i < N; i++) begin
            if (i == 0) begin
                vd[i] = 1'b0; vs[i] = 1'b0; vr[i] = 1'b1;
            end else begin
                x = step(x);
                vd[i] = x[0];
                vs[i] = ((x >> 3) & (x >> 5) & 8'd1) != 0;
                vr[i] = ((x >> 2) & (x >> 6) & (x >> 7) & 8'd1) != 0;
            end
            ve[i] = vr[i] ? 1'b0 : (vs[i] ? 1'b1 : vd[i]);
        end
    endtask

    task automatic run_main(input int hold, input bit late_start);
        int cyc;
        cyc = 0;
        nbusy = 0;
        drain_nonzero = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        while (busy && cyc < 400) begin
            if (cyc < N) begin
                od[cyc] = dut_d; os[cyc] = dut_Set; obs_r[cyc] = dut_Reset;
            end else if (dut_d || dut_Set || dut_Reset) begin
                drain_nonzero = 1'b1;
            end
            start = (cyc + 1 < hold) || (late_start && cyc == N);
            nbusy++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mode = 0;
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, pass} !== 3'b000) begin errors++;
            $display("FAIL reset_flags: got %b expected 000", {busy, done, pass}); end
        checks++; if ({dut_d, dut_Set, dut_Reset} !== 3'b000) begin errors++;
            $display("FAIL reset_stim: got %b expected 000", {dut_d, dut_Set, dut_Reset}); end
        checks++; if (err_count !== 8'd0) begin errors++;
            $display("FAIL reset_err: got %0d expected 0", err_count); end
        checks++; if (first_err_idx !== 8'hFF) begin errors++;
            $display("FAIL reset_fidx: got %h expected ff", first_err_idx); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, first_err_idx} !== {2'b00, 8'hFF}) begin errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b fidx=%h expected 0 0 ff", busy, done, first_err_idx); end
    endtask

    task automatic test_correct();
        int bad;
        mode = 0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        run_main(1, 0);
        checks++; if (nbusy != N + 1) begin errors++;
            $display("FAIL busy_len: got %0d expected %0d", nbusy, N + 1); end
        checks++; if ({od[0], os[0], obs_r[0]} !== 3'b001) begin errors++;
            $display("FAIL first_vector: got %b expected 001", {od[0], os[0], obs_r[0]}); end
        bad = 0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({od[i], os[i], obs_r[i]} !== {vd[i], vs[i], vr[i]}) begin
                errors++; bad++;
                if (bad < 5) $display("FAIL vector %0d: got %b expected %b", i,
                    {od[i], os[i], obs_r[i]}, {vd[i], vs[i], vr[i]});
            end
        end
        checks++; if (drain_nonzero !== 1'b0) begin errors++;
            $display("FAIL drain_stim: got nonzero expected 000"); end
        checks++; if ({done, pass, busy} !== 3'b110) begin errors++;
            $display("FAIL correct_flags: got done/pass/busy=%b expected 110", {done, pass, busy}); end
        checks++; if (err_count !== 8'd0) begin errors++;
            $display("FAIL correct_err: got %0d expected 0", err_count); end
        checks++; if (first_err_idx !== 8'hFF) begin errors++;
            $display("FAIL correct_fidx: got %h expected ff", first_err_idx); end
    endtask

    task automatic test_done_hold();
        mode = 0;
        run_main(1, 1);
        checks++; if ({done, busy} !== 2'b10) begin errors++;
            $display("FAIL late_start: got done/busy=%b expected 10", {done, busy}); end
        repeat ($urandom_range(2, 8)) @(negedge clk);
        checks++; if ({done, pass, busy, err_count} !== {3'b110, 8'd0}) begin errors++;
            $display("FAIL done_hold: got done=%b pass=%b busy=%b err=%0d expected 1 1 0 0",
                done, pass, busy, err_count); end
    endtask

    task automatic test_stuck();
        int cnt; int first;
        cnt = 0; first = 255;
        for (int i = 0; i < N; i++) if (ve[i]) begin cnt++; if (first == 255) first = i; end
        mode = 1;
        run_main(1, 0);
        checks++; if (pass !== (cnt == 0)) begin errors++;
            $display("FAIL stuck_pass: got %b expected %b", pass, cnt == 0); end
        checks++; if (err_count !== 8'(cnt)) begin errors++;
            $display("FAIL stuck_err: got %0d expected %0d", err_count, cnt); end
        checks++; if (first_err_idx !== 8'(first)) begin errors++;
            $display("FAIL stuck_fidx: got %0d expected %0d", first_err_idx, first); end
    endtask

    task automatic test_set_dom();
        int cnt; int first;
        cnt = 0; first = 255;
        for (int i = 0; i < N; i++) if (vs[i] && vr[i]) begin cnt++; if (first == 255) first = i; end
        mode = 2;
        run_main(1, 0);
        checks++; if (err_count !== 8'(cnt)) begin errors++;
            $display("FAIL setdom_err: got %0d expected %0d", err_count, cnt); end
        checks++; if (first_err_idx !== 8'(first)) begin errors++;
            $display("FAIL setdom_fidx: got %0d expected %0d", first_err_idx, first); end
        checks++; if (pass !== (cnt == 0)) begin errors++;
            $display("FAIL setdom_pass: got %b expected %b", pass, cnt == 0); end
    endtask

    task automatic test_nq_tied();
        mode = 3;
        run_main(1, 0);
        checks++; if (err_count !== 8'(N)) begin errors++;
            $display("FAIL nqtied_err: got %0d expected %0d", err_count, N); end
        checks++; if (first_err_idx !== 8'd0) begin errors++;
            $display("FAIL nqtied_fidx: got %0d expected 0", first_err_idx); end
        checks++; if ({done, pass} !== 2'b10) begin errors++;
            $display("FAIL nqtied_flags: got done/pass=%b expected 10", {done, pass}); end
    endtask

    task automatic test_saturate();
        int cnt; int first; int budget;
        cnt = 0; first = 255; budget = 0;
        for (int i = 0; i < N; i++) if (ve[i]) begin cnt++; if (first == 255) first = i; end
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        while (!done2 && budget < 400) begin budget++; @(negedge clk); end
        checks++; if (done2 !== 1'b1) begin errors++;
            $display("FAIL sat_timeout: got done=%b expected 1", done2); end
        checks++; if (err2 !== 2'((cnt > 3) ? 3 : cnt)) begin errors++;
            $display("FAIL sat_err: got %0d expected %0d", err2, (cnt > 3) ? 3 : cnt); end
        checks++; if (fidx2 !== 8'(first)) begin errors++;
            $display("FAIL sat_fidx: got %0d expected %0d", fidx2, first); end
        checks++; if (pass2 !== (cnt == 0)) begin errors++;
            $display("FAIL sat_pass: got %b expected %b", pass2, cnt == 0); end
    endtask

    task automatic test_reset_midrun();
        int bad;
        mode = 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat ($urandom_range(10, 50)) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, pass, dut_d, dut_Set, dut_Reset} !== 6'b0) begin errors++;
            $display("FAIL abort_flags: got %b expected 000000",
                {busy, done, pass, dut_d, dut_Set, dut_Reset}); end
        checks++; if ({err_count, first_err_idx} !== {8'd0, 8'hFF}) begin errors++;
            $display("FAIL abort_result: got err=%0d fidx=%h expected 0 ff", err_count, first_err_idx); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) begin errors++;
            $display("FAIL abort_idle: got busy/done=%b expected 00", {busy, done}); end
        mode = 0;
        run_main($urandom_range(3, 20), 0);
        checks++; if (nbusy != N + 1) begin errors++;
            $display("FAIL rerun_busy_len: got %0d expected %0d", nbusy, N + 1); end
        bad = 0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({od[i], os[i], obs_r[i]} !== {vd[i], vs[i], vr[i]}) begin
                errors++; bad++;
                if (bad < 5) $display("FAIL rerun_vector %0d: got %b expected %b", i,
                    {od[i], os[i], obs_r[i]}, {vd[i], vs[i], vr[i]});
            end
        end
        checks++; if ({done, pass, err_count, first_err_idx} !== {2'b11, 8'd0, 8'hFF}) begin errors++;
            $display("FAIL rerun_result: got done=%b pass=%b err=%0d fidx=%h expected 1 1 0 ff",
                done, pass, err_count, first_err_idx); end
    endtask

    initial begin
        build_model();
        test_reset();
        test_correct();
        test_done_hold();
        test_stuck();
        test_set_dom();
        test_nq_tied();
        test_saturate();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
